// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-width codes,
// FSM state encoding and the load lane-select / extension helper.
package dmem_pkg;

    // Default geometry: 256 words of 32 bits, giving byte addresses 0..1023.
    localparam int DMEM_DEPTH_WORDS = 256;
    localparam int DMEM_AW          = $clog2(DMEM_DEPTH_WORDS);

    // funct3 codes carried on lorbtype.
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Pick the addressed byte/half out of a RAM word and extend it to 32 bits.
    // Byte lanes come from off[1:0], half lanes from off[1]. Unknown codes yield 0.
    function automatic logic [31:0] ext_load(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    res = {{24{b[7]}}, b};
            F3_BU:   res = {24'd0, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_HU:   res = {16'd0, h};
            F3_W:    res = word;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised synchronous RAM with four byte-wide write lanes.
// One-cycle registered read; read data holds while re is low.
// Contents are not reset.
module dmem_byte_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int AW          = DMEM_AW
) (
    input  logic          clk,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata
);

    logic [3:0][7:0] mem [DEPTH_WORDS];

    // Byte-enable write: each lane is updated only when its enable is set.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (we && be[l]) begin
                mem[waddr][l] <= wdata[8*l +: 8];
            end
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: services level-held load/store requests from the
// instruction controller with byte/half/word access, sign/zero extension and
// rejection of misaligned, out-of-range or illegal-width requests.
//
// Handshake: read_mem / write_mem are levels, sampled only in IDLE. A request
// seen in IDLE is answered two cycles later by a single-cycle mem_ready pulse
// with fault valid alongside it; rdata holds until the next pulse. The
// responder then waits in HOLD until both request lines drop, so a request
// that stays high is serviced exactly once.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_mem,
    input  logic        write_mem,
    input  logic [2:0]  lorbtype,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mem_ready,
    output logic        fault
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    // FSM state; named so checkers can observe it directly.
    state_t      state;

    // Request captured in IDLE; everything after IDLE works from these.
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [2:0]  cap_f3;
    logic        cap_rd;
    logic        cap_wr;

    // Legality and write-lane decode.
    logic        misaligned;
    logic        out_of_range;
    logic        bad_f3;
    logic        illegal;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;

    // RAM interface.
    logic        ram_re;
    logic        ram_we;
    logic [31:0] ram_q;

    // Classify the captured request; any reason makes it illegal.
    always_comb begin
        misaligned   = 1'b0;
        bad_f3       = 1'b0;
        out_of_range = (cap_addr >= ADDR_LIMIT);
        case (cap_f3[1:0])
            2'd1:    misaligned = cap_addr[0];
            2'd2:    misaligned = |cap_addr[1:0];
            default: misaligned = 1'b0;
        endcase
        if (cap_wr) begin
            bad_f3 = (cap_f3 >= 3'd3);
        end else begin
            bad_f3 = (cap_f3 == 3'd3) || (cap_f3 == 3'd6) || (cap_f3 == 3'd7);
        end
        illegal = (cap_rd && cap_wr) || misaligned || out_of_range || bad_f3;
    end

    // Lane enables and lane-replicated store data for sb/sh/sw.
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = cap_wdata;
        case (cap_f3[1:0])
            2'd0: begin
                wr_be   = 4'b0001 << cap_addr[1:0];
                wr_data = {4{cap_wdata[7:0]}};
            end
            2'd1: begin
                wr_be   = cap_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{cap_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = cap_wdata;
            end
        endcase
    end

    // The read is launched from the live address while idle, so the word is
    // already on ram_q during ACCESS and rdata can be loaded entering RESP.
    // A store commits on the edge leaving ACCESS unless reset is asserted.
    always_comb begin
        ram_re = (state == ST_IDLE);
        ram_we = (state == ST_ACCESS) && cap_wr && !illegal && rst_n;
    end

    dmem_byte_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .re   (ram_re),
        .raddr(addr[AW+1:2]),
        .rdata(ram_q),
        .we   (ram_we),
        .be   (wr_be),
        .waddr(cap_addr[AW+1:2]),
        .wdata(wr_data)
    );

    // Request FSM with registered capture and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rdata     <= 32'd0;
            mem_ready <= 1'b0;
            fault     <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_f3    <= 3'd0;
            cap_rd    <= 1'b0;
            cap_wr    <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            fault     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (read_mem || write_mem) begin
                        cap_addr  <= addr;
                        cap_wdata <= wdata;
                        cap_f3    <= lorbtype;
                        cap_rd    <= read_mem;
                        cap_wr    <= write_mem;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    mem_ready <= 1'b1;
                    fault     <= illegal;
                    if (cap_rd && !illegal) begin
                        rdata <= ext_load(ram_q, cap_addr[1:0], cap_f3);
                    end else begin
                        rdata <= 32'd0;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!read_mem && !write_mem) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array reference model, directed cases for
// lanes/extension/faults/hold/reset, then randomized requests.
module tb_dmem_responder;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        read_mem;
    logic        write_mem;
    logic [2:0]  lorbtype;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mem_ready;
    logic        fault;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .read_mem (read_mem),
        .write_mem(write_mem),
        .lorbtype (lorbtype),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .mem_ready(mem_ready),
        .fault    (fault)
    );

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  mdl [1024];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: memory as a flat byte array, rules straight from the
    // access definition (size, alignment, range, legal codes, extension).
    function automatic void model(input bit rd, input bit wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output bit flt, output logic [31:0] rv);
        int size;
        bit bad;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        bad  = rd && wr;
        if (wr && f3 >= 3) bad = 1;
        if (!wr && (f3 == 3 || f3 == 6 || f3 == 7)) bad = 1;
        if ((a % 32'(size)) != 0) bad = 1;
        if (a >= 32'd1024) bad = 1;
        flt = bad;
        rv  = 32'd0;
        if (!bad && wr) begin
            for (int i = 0; i < size; i++) mdl[int'(a) + i] = wd[8*i +: 8];
        end
        if (!bad && !wr) begin
            for (int i = 0; i < size; i++) rv |= 32'(mdl[int'(a) + i]) << (8*i);
            if (f3[2] == 1'b0 && size < 4 && rv[8*size-1]) rv |= (32'hFFFF_FFFF << (8*size));
        end
    endfunction

    function automatic logic [31:0] mdl_word(input int a);
        return {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]};
    endfunction

    // ---------------- driver ----------------
    // Entered one step after a rising edge with the DUT idle; leaves it idle.
    task automatic do_req(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] got);
        bit          ef;
        logic [31:0] ev;
        model(rd, wr, f3, a, wd, ef, ev);
        exp_q.push_back(ev);
        read_mem  = rd;
        write_mem = wr;
        lorbtype  = f3;
        addr      = a;
        wdata     = wd;
        @(posedge clk); #1;
        check("ready_early", 32'(mem_ready), 32'd0);
        // Changes after capture must be ignored.
        addr     = $urandom;
        lorbtype = 3'($urandom_range(0, 7));
        wdata    = $urandom;
        @(posedge clk); #1;
        check("ready_pulse", 32'(mem_ready), 32'd1);
        check("fault", 32'(fault), 32'(ef));
        got = rdata;
        check("rdata", rdata, exp_q.pop_front());
        read_mem  = 1'b0;
        write_mem = 1'b0;
        @(posedge clk); #1;
        check("ready_single", 32'(mem_ready), 32'd0);
        check("rdata_hold", rdata, ev);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] got;
        logic [31:0] prior;
        int          pulses;
        bit          ef;
        logic [31:0] ev;

        rst_n = 1'b0; read_mem = 1'b0; write_mem = 1'b0;
        lorbtype = 3'd0; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 32'd0);
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill every word so the model knows all RAM contents.
        for (int w = 0; w < 256; w++) do_req(1'b0, 1'b1, 3'd2, 32'(4*w), $urandom, got);

        // Word store/load and lane extension.
        do_req(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, got);
        do_req(1'b1, 1'b0, 3'd2, 32'h10, 32'd0, got); check("lw10", got, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 3'd0, 32'h13, 32'd0, got); check("lb13", got, 32'hFFFFFFDE);
        do_req(1'b1, 1'b0, 3'd4, 32'h13, 32'd0, got); check("lbu13", got, 32'h000000DE);
        do_req(1'b1, 1'b0, 3'd1, 32'h12, 32'd0, got); check("lh12", got, 32'hFFFFDEAD);
        do_req(1'b1, 1'b0, 3'd5, 32'h10, 32'd0, got); check("lhu10", got, 32'h0000BEEF);
        do_req(1'b0, 1'b1, 3'd0, 32'h11, 32'h00000055, got);
        do_req(1'b1, 1'b0, 3'd2, 32'h10, 32'd0, got); check("sb_lw", got, 32'hDEAD55EF);
        do_req(1'b0, 1'b1, 3'd1, 32'h12, 32'h00001234, got);
        do_req(1'b1, 1'b0, 3'd2, 32'h10, 32'd0, got); check("sh_lw", got, 32'h123455EF);

        // Rejected requests; memory must stay untouched.
        do_req(1'b1, 1'b0, 3'd2, 32'h12, 32'd0, got);
        do_req(1'b1, 1'b0, 3'd1, 32'h11, 32'd0, got);
        do_req(1'b0, 1'b1, 3'd2, 32'h400, 32'hCAFEF00D, got);
        do_req(1'b1, 1'b0, 3'd3, 32'h10, 32'd0, got);
        do_req(1'b1, 1'b1, 3'd2, 32'h10, 32'h0BADF00D, got);
        do_req(1'b0, 1'b1, 3'd2, 32'h12, 32'h0BADF00D, got);
        do_req(1'b1, 1'b0, 3'd2, 32'h10, 32'd0, got); check("fault_nochg", got, 32'h123455EF);

        // Level held for 10 cycles: one pulse only.
        model(1'b1, 1'b0, 3'd2, 32'h10, 32'd0, ef, ev);
        read_mem = 1'b1; lorbtype = 3'd2; addr = 32'h10;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            pulses += int'(mem_ready);
        end
        check("held_pulses", 32'(pulses), 32'd1);
        check("held_rdata", rdata, ev);
        read_mem = 1'b0;
        @(posedge clk); #1;
        read_mem = 1'b1;
        @(posedge clk); #1;
        check("reassert_early", 32'(mem_ready), 32'd0);
        @(posedge clk); #1;
        check("reassert_pulse", 32'(mem_ready), 32'd1);
        check("reassert_rdata", rdata, ev);
        read_mem = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Store aborted by reset on its commit edge.
        prior = mdl_word(32'h20);
        read_mem = 1'b0; write_mem = 1'b1; lorbtype = 3'd2;
        addr = 32'h20; wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rstabort_ready", 32'(mem_ready), 32'd0);
        check("rstabort_fault", 32'(fault), 32'd0);
        check("rstabort_rdata", rdata, 32'd0);
        rst_n = 1'b1; write_mem = 1'b0;
        @(posedge clk); #1;
        do_req(1'b1, 1'b0, 3'd2, 32'h20, 32'd0, got); check("rstabort_mem", got, prior);

        // Randomized requests against the model.
        for (int n = 0; n < 250; n++) begin
            int          k;
            bit          rd;
            bit          wr;
            logic [2:0]  f3;
            logic [31:0] a;
            k  = $urandom_range(0, 19);
            rd = (k == 0) || (k < 11);
            wr = (k == 0) || (k >= 11);
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else begin
                k = $urandom_range(0, 4);
                f3 = (k == 0) ? 3'd0 : (k == 1) ? 3'd1 : (k == 2) ? 3'd2 : (k == 3) ? 3'd4 : 3'd5;
            end
            if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(1000, 1160));
            else a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
                if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            do_req(rd, wr, f3, a, $urandom, got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Run-time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
